// File: rtl/decoder_rr_arbiter_4.sv
// ---------------------------------------------------------------------------
// decoder_rr_arbiter_4
//   Round-robin arbiter that shares one 4-way active-low select decoder among
//   four requesters. The registered winner index drives the decoder select
//   (sel). A matching one-cold active-low grant vector (grant_n) gives
//   downstream logic decoder-style enables.
//   Each grant lasts at most MAX_HOLD cycles. Between grants there is a fixed
//   dead time of GAP cycles plus one arbitration cycle.
//
// Parameters
//   MAX_HOLD : max cycles a grant is held before a forced revoke (>=1)
//   GAP      : idle cycles with all grants released between grants (>=1)
//
// Ports
//   clk     in   1  system clock, rising edge
//   rst     in   1  asynchronous active-high reset
//   req     in   4  level request per agent, bit i = agent i
//   sel     out  2  index of the current/last winner (decoder select)
//   grant_n out  4  one-cold active-low grant, 4'b1111 = no grant
//   busy    out  1  high while a grant is asserted
//   timeout out  1  one-cycle pulse on a forced revoke at MAX_HOLD
// ---------------------------------------------------------------------------
module decoder_rr_arbiter_4 #(
  parameter int MAX_HOLD = 16,
  parameter int GAP      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] grant_n,
  output logic       busy,
  output logic       timeout
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sel;
  logic [1:0]      r_last;
  logic [3:0]      r_grant_n;
  logic            r_busy;
  logic            r_timeout;
  logic [HW-1:0]   r_hold_cnt;
  logic [GW-1:0]   r_gap_cnt;

  logic [1:0]      w_winner;
  logic [1:0]      w_idx;
  logic            w_any_req;
  logic            w_owner_req;
  logic            w_hold_max;
  logic            w_gap_done;

  assign w_any_req   = |req;
  assign w_owner_req = req[r_sel];
  assign w_hold_max  = (r_hold_cnt == HW'(MAX_HOLD));
  assign w_gap_done  = (r_gap_cnt == GW'(GAP));

  // Rotating priority search: scan from last+4 down to last+1 so the final
  // assignment is the requester closest after the previous winner.
  always_comb begin
    w_winner = r_last;
    w_idx    = r_last;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_last + 2'(k);
      if (req[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sel      <= 2'd0;
      r_last     <= 2'd3;
      r_grant_n  <= 4'b1111;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state    <= S_GRANT;
            r_sel      <= w_winner;
            r_last     <= w_winner;
            r_grant_n  <= ~(4'b0001 << w_winner);
            r_busy     <= 1'b1;
            r_hold_cnt <= HW'(1);
          end
        end
        S_GRANT: begin
          // A release on the MAX_HOLD cycle wins over the forced revoke,
          // so timeout only fires when the owner still wants the bus.
          if (!w_owner_req || w_hold_max) begin
            r_state   <= S_GAP;
            r_grant_n <= 4'b1111;
            r_busy    <= 1'b0;
            r_gap_cnt <= GW'(1);
            r_timeout <= w_owner_req;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        S_GAP: begin
          if (w_gap_done) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_grant_n <= 4'b1111;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign sel     = r_sel;
  assign grant_n = r_grant_n;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule
